link_aligner: RTL

- Parametrised per-channel receive block-alignment manager for the node/controller transceiver mesh.
- Generalises the fixed 12-link, 3-node wiring to C channels.
- For each channel: watches received 6-bit headers, pulses rx_slip until headers lock, declares link_up, and drops lock on excessive header errors.
- Sits between the transceiver rx ports and the node/controller logic; all_up gates mesh traffic start.

---
 rtl/link_aligner_pkg.sv | 24 ++
 rtl/link_align_channel.sv | 165 ++++++++++++++++
 rtl/link_aligner.sv | 68 ++++++
 3 files changed

// File: rtl/link_aligner_pkg.sv
// Shared types and helpers for the per-channel receive block aligner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package link_aligner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        SLIP   = 2'd2,
        LOCKED = 2'd3
    } align_state_t;

    // Only these two sync patterns mark a correctly framed block.
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int          STAT_W   = 8;
    localparam logic [7:0]  STAT_MAX = 8'hFF;

    function automatic logic is_good_header(input logic [1:0] sync);
        return (sync == SYNC_DATA) || (sync == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/link_align_channel.sv
// One receive channel: hunts for header lock, requests gearbox slips, monitors errors.
// Latency: slip and lock status are registered, visible the cycle after the deciding header.
// Backpressure: none; headers are consumed every cycle rx valid is high.
//
// Ports: clock, reset_n (sync, active-low), activate (low forces IDLE),
//        valid/sync (header strobe and its two sync bits), slip (1-cycle gearbox
//        request), locked (channel up). With LINK_ALIGNER_STATS_EN defined,
//        loss_count and slip_count expose saturating 8-bit event counters.
module link_align_channel
    import link_aligner_pkg::*;
#(
    parameter int LOCK_COUNT = 64,
    parameter int SLIP_WAIT  = 32,
    parameter int WINDOW     = 64,
    parameter int BAD_LIMIT  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              activate,
    input  logic              valid,
    input  logic [1:0]        sync,
    output logic              slip,
    output logic              locked
`ifdef LINK_ALIGNER_STATS_EN
    ,
    output logic [STAT_W-1:0] loss_count,
    output logic [STAT_W-1:0] slip_count
`endif
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam int HW = $clog2(WINDOW + 1);
    localparam int BW = $clog2(BAD_LIMIT + 1);

    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
    localparam logic [WW-1:0] WAIT_MAX = WW'(SLIP_WAIT);
    localparam logic [HW-1:0] HDR_MAX  = HW'(WINDOW);
    localparam logic [BW-1:0] BAD_MAX  = BW'(BAD_LIMIT);

    align_state_t  state, state_nxt;
    logic [GW-1:0] good_cnt, good_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [HW-1:0] hdr_cnt,  hdr_nxt;
    logic [BW-1:0] bad_cnt,  bad_nxt;
    logic          slip_q,   slip_nxt;
    logic          hdr_good;

    assign hdr_good = is_good_header(sync);

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        wait_nxt  = wait_cnt;
        hdr_nxt   = hdr_cnt;
        bad_nxt   = bad_cnt;
        slip_nxt  = 1'b0;

        if (!activate) begin
            // Dropping activate wins over everything, including a slip that
            // would otherwise be issued this cycle.
            state_nxt = IDLE;
            good_nxt  = '0;
            wait_nxt  = '0;
            hdr_nxt   = '0;
            bad_nxt   = '0;
        end else begin
            case (state)
                IDLE: state_nxt = HUNT;

                HUNT: begin
                    if (valid && !hdr_good) begin
                        slip_nxt  = 1'b1;
                        good_nxt  = '0;
                        wait_nxt  = '0;
                        state_nxt = SLIP;
                    end else if (valid) begin
                        good_nxt = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
                        if (good_nxt == GOOD_MAX) begin
                            // Start the locked phase with fresh window counters and
                            // a clean run count for any later re-hunt.
                            good_nxt  = '0;
                            hdr_nxt   = '0;
                            bad_nxt   = '0;
                            state_nxt = LOCKED;
                        end
                    end
                end

                SLIP: begin
                    // Gearbox needs time to settle; headers here are meaningless.
                    wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WW'(1);
                    if (wait_nxt == WAIT_MAX) begin
                        wait_nxt  = '0;
                        state_nxt = HUNT;
                    end
                end

                LOCKED: begin
                    if (valid) begin
                        hdr_nxt = (hdr_cnt == HDR_MAX) ? hdr_cnt : hdr_cnt + HW'(1);
                        if (!hdr_good) begin
                            bad_nxt = (bad_cnt == BAD_MAX) ? bad_cnt : bad_cnt + BW'(1);
                        end
                        // Loss of lock is checked first so an error limit hit on the
                        // last header of a window is not erased by the window clear.
                        if (bad_nxt == BAD_MAX) begin
                            hdr_nxt   = '0;
                            bad_nxt   = '0;
                            state_nxt = HUNT;
                        end else if (hdr_nxt == HDR_MAX) begin
                            hdr_nxt = '0;
                            bad_nxt = '0;
                        end
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            good_cnt <= '0;
            wait_cnt <= '0;
            hdr_cnt  <= '0;
            bad_cnt  <= '0;
            slip_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            wait_cnt <= wait_nxt;
            hdr_cnt  <= hdr_nxt;
            bad_cnt  <= bad_nxt;
            slip_q   <= slip_nxt;
        end
    end

    assign slip   = slip_q;
    assign locked = (state == LOCKED);

`ifdef LINK_ALIGNER_STATS_EN
    logic lost;

    // activate=0 always leads to IDLE, so this only catches error-driven losses.
    assign lost = (state == LOCKED) && (state_nxt == HUNT);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            loss_count <= '0;
            slip_count <= '0;
        end else begin
            if (lost && (loss_count != STAT_MAX)) begin
                loss_count <= loss_count + 8'd1;
            end
            if (slip_nxt && (slip_count != STAT_MAX)) begin
                slip_count <= slip_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/link_aligner.sv
// Receive block-alignment manager for C transceiver channels; all_up gates mesh traffic.
// Latency: per-channel status as in link_align_channel; all_up one cycle after link_up.
// Backpressure: none; every valid header is consumed.
//
// Ports: clock, reset_n (sync, active-low), activate, rx_valid[C],
//        rx_header[HW*C] (channel i at [i*HW +: HW], sync bits [1:0]),
//        rx_slip[C], link_up[C], all_up.
// Optional: define LINK_ALIGNER_STATS_EN to add loss_count[8*C] and slip_count[8*C].
module link_aligner
    import link_aligner_pkg::*;
#(
    parameter int C          = 12,
    parameter int HW         = 6,
    parameter int LOCK_COUNT = 64,
    parameter int SLIP_WAIT  = 32,
    parameter int WINDOW     = 64,
    parameter int BAD_LIMIT  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  activate,
    input  logic [C-1:0]          rx_valid,
    input  logic [HW*C-1:0]       rx_header,
    output logic [C-1:0]          rx_slip,
    output logic [C-1:0]          link_up,
    output logic                  all_up
`ifdef LINK_ALIGNER_STATS_EN
    ,
    output logic [STAT_W*C-1:0]   loss_count,
    output logic [STAT_W*C-1:0]   slip_count
`endif
);

    // Payload bits above the sync field are not inspected by the aligner.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^rx_header;

    for (genvar i = 0; i < C; i++) begin : g_chan
        link_align_channel #(
            .LOCK_COUNT (LOCK_COUNT),
            .SLIP_WAIT  (SLIP_WAIT),
            .WINDOW     (WINDOW),
            .BAD_LIMIT  (BAD_LIMIT)
        ) u_chan (
            .clock      (clock),
            .reset_n    (reset_n),
            .activate   (activate),
            .valid      (rx_valid[i]),
            .sync       (rx_header[i*HW +: 2]),
            .slip       (rx_slip[i]),
            .locked     (link_up[i])
`ifdef LINK_ALIGNER_STATS_EN
            ,
            .loss_count (loss_count[i*STAT_W +: STAT_W]),
            .slip_count (slip_count[i*STAT_W +: STAT_W])
`endif
        );
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            all_up <= 1'b0;
        end else begin
            all_up <= &link_up;
        end
    end

endmodule
